mcp_adc_scanner: RTL and testbench

Parametrised successor to the single-channel MCP SPI ADC reader. Drives an MCP3x08-style SPI ADC (10/12-bit, up to 8 channels) and scans a programmable channel mask in single-shot or continuous mode. Optionally averages 2^AVG_LOG2 conversions per channel. Delivers tagged samples to the LCD/LED logic through a one-cycle valid pulse.

---
 rtl/mcp_adc_scanner.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mcp_adc_scanner.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp_adc_scanner.sv
// Multi-channel MCP3x08-style SPI ADC scanner with optional per-channel averaging.
// Optional hysteresis alarm on delivered samples is built when ADC_ALARM_EN is defined.
module mcp_adc_scanner #(
    parameter int CLK_DIV  = 4,
    parameter int NUM_CH   = 8,
    parameter int ADC_BITS = 10,
    parameter int AVG_LOG2 = 0,
    parameter int CS_HIGH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cont,
    input  logic [7:0]          ch_mask,
    output logic                cs,
    output logic                sclk,
    output logic                din,
    input  logic                dout,
    output logic                busy,
    output logic                sample_valid,
    output logic [2:0]          sample_ch,
    output logic [ADC_BITS-1:0] sample_data,
    output logic                alarm,
    input  logic [ADC_BITS-1:0] thr_hi,
    input  logic [ADC_BITS-1:0] thr_lo
);

    localparam int FRAME   = 6 + ADC_BITS;
    localparam int ACC_W   = ADC_BITS + AVG_LOG2;
    localparam int CNT_MAX = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int CONV_W  = AVG_LOG2 + 1;

    localparam logic [7:0]        EN_MASK    = 8'((9'd1 << NUM_CH) - 9'd1);
    localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(CS_HIGH - 1);
    localparam logic [4:0]        FRAME_LAST = 5'(FRAME);
    localparam logic [CONV_W-1:0] CONV_LAST  = CONV_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_ACCUM, S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    div_q, div_d;
    logic [4:0]          bit_q, bit_d;
    logic [2:0]          ch_q, ch_d;
    logic [7:0]          mask_q, mask_d;
    logic [ADC_BITS-1:0] shreg_q, shreg_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CONV_W-1:0]   conv_q, conv_d;
    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                din_q, din_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [2:0]          sample_ch_q, sample_ch_d;
    logic [ADC_BITS-1:0] sample_data_q, sample_data_d;

    // Index of the lowest set bit at or above 'from'; 8 means none.
    function automatic logic [3:0] lowest_from(input logic [7:0] m, input logic [3:0] from);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (4'(i) >= from)) r = 4'(i);
        end
        return r;
    endfunction

    logic [7:0]       new_mask;
    logic [3:0]       new_first;
    logic [3:0]       next_in_scan;
    logic [4:0]       cmd_shl;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] avg;

    always_comb begin
        new_mask     = ch_mask & EN_MASK;
        new_first    = lowest_from(new_mask, 4'd0);
        next_in_scan = lowest_from(mask_q, {1'b0, ch_q} + 4'd1);
        // Command is start, SGL, D2..D0; shifting by the edge count yields the next bit.
        cmd_shl      = {2'b11, ch_q} << bit_q;
        acc_sum      = acc_q + ACC_W'(shreg_q);
        avg          = acc_sum >> AVG_LOG2;
    end

    always_comb begin
        logic launch;
        launch        = 1'b0;
        state_d       = state_q;
        div_d         = div_q;
        bit_d         = bit_q;
        ch_d          = ch_q;
        mask_d        = mask_q;
        shreg_d       = shreg_q;
        acc_d         = acc_q;
        conv_d        = conv_q;
        cs_d          = cs_q;
        sclk_d        = sclk_q;
        din_d         = din_q;
        busy_d        = busy_q;
        valid_d       = 1'b0;
        sample_ch_d   = sample_ch_q;
        sample_data_d = sample_data_q;

        case (state_q)
            S_IDLE: begin
                if (start && (new_mask != 8'd0)) begin
                    mask_d = new_mask;
                    ch_d   = new_first[2:0];
                    busy_d = 1'b1;
                    acc_d  = '0;
                    conv_d = '0;
                    launch = 1'b1;
                end
            end
            S_CS_SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_SHIFT;
                    sclk_d  = 1'b1;
                    bit_d   = 5'd1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q == FRAME_LAST) begin
                            state_d = S_CS_HOLD;
                            din_d   = 1'b0;
                        end else begin
                            din_d = cmd_shl[4];
                        end
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 5'd1;
                        // Rising edges 7 and later carry conversion bits, MSB first.
                        if (bit_q >= 5'd6) shreg_d = {shreg_q[ADC_BITS-2:0], dout};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_CS_HOLD: begin
                if (div_q == DIV_LAST) begin
                    cs_d    = 1'b1;
                    state_d = S_ACCUM;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_ACCUM: begin
                if (conv_q == CONV_LAST) begin
                    sample_data_d = avg[ADC_BITS-1:0];
                    sample_ch_d   = ch_q;
                    valid_d       = 1'b1;
                    acc_d         = '0;
                    conv_d        = '0;
                end else begin
                    acc_d  = acc_sum;
                    conv_d = conv_q + 1'b1;
                end
                state_d = S_GAP;
                div_d   = '0;
            end
            S_GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d = '0;
                    if (conv_q != '0) begin
                        launch = 1'b1;
                    end else if (next_in_scan != 4'd8) begin
                        ch_d   = next_in_scan[2:0];
                        launch = 1'b1;
                    end else if (cont && (new_mask != 8'd0)) begin
                        mask_d = new_mask;
                        ch_d   = new_first[2:0];
                        launch = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            state_d = S_CS_SETUP;
            cs_d    = 1'b0;
            sclk_d  = 1'b0;
            din_d   = 1'b1;
            div_d   = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            bit_q         <= '0;
            ch_q          <= '0;
            mask_q        <= '0;
            shreg_q       <= '0;
            acc_q         <= '0;
            conv_q        <= '0;
            cs_q          <= 1'b1;
            sclk_q        <= 1'b0;
            din_q         <= 1'b0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
            sample_ch_q   <= '0;
            sample_data_q <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            ch_q          <= ch_d;
            mask_q        <= mask_d;
            shreg_q       <= shreg_d;
            acc_q         <= acc_d;
            conv_q        <= conv_d;
            cs_q          <= cs_d;
            sclk_q        <= sclk_d;
            din_q         <= din_d;
            busy_q        <= busy_d;
            valid_q       <= valid_d;
            sample_ch_q   <= sample_ch_d;
            sample_data_q <= sample_data_d;
        end
    end

    assign cs           = cs_q;
    assign sclk         = sclk_q;
    assign din          = din_q;
    assign busy         = busy_q;
    assign sample_valid = valid_q;
    assign sample_ch    = sample_ch_q;
    assign sample_data  = sample_data_q;

`ifdef ADC_ALARM_EN
    logic alarm_q, alarm_d;

    // Hysteresis: set at or above thr_hi, clear at or below thr_lo, else hold.
    always_comb begin
        alarm_d = alarm_q;
        if (valid_q) begin
            if (sample_data_q >= thr_hi)      alarm_d = 1'b1;
            else if (sample_data_q <= thr_lo) alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) alarm_q <= 1'b0;
        else     alarm_q <= alarm_d;
    end

    assign alarm = alarm_q;
`else
    logic unused_thr;
    assign unused_thr = ^{thr_hi, thr_lo};
    assign alarm      = 1'b0;
`endif

endmodule

// File: tb/tb_mcp_adc_scanner.sv
// Directed bench for mcp_adc_scanner: two instances (no averaging / 4x averaging) with a
// behavioural MCP3x08 model each.
module tb_mcp_adc_scanner;
    localparam int AB = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_r [2];
    logic cont_r [2];
    logic [7:0] mask_r [2];
    logic [AB-1:0] thr_hi, thr_lo;
    logic cs_w [2], sclk_w [2], din_w [2], busy_w [2], valid_w [2], alarm_w [2];
    logic [2:0] ch_w [2];
    logic [AB-1:0] data_w [2];
    logic [AB-1:0] conv_tab [2][32];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            logic dout_m = 1'b0;
            int rise_cnt = 0, fidx = 0, last_rises = 0, sedges = 0, vn = 0;
            int cs_hi_cnt = 0, min_gap = 1000;
            logic [4:0] cmd_cap = '0, last_cmd = '0;
            logic [AB-1:0] cur_val = '0;
            logic [12:0] vlog [128];

            mcp_adc_scanner #(
                .CLK_DIV(2), .NUM_CH(8), .ADC_BITS(AB), .AVG_LOG2(gi * 2), .CS_HIGH(8)
            ) u_dut (
                .clk(clk), .rst(rst), .start(start_r[gi]), .cont(cont_r[gi]),
                .ch_mask(mask_r[gi]), .cs(cs_w[gi]), .sclk(sclk_w[gi]), .din(din_w[gi]),
                .dout(dout_m), .busy(busy_w[gi]), .sample_valid(valid_w[gi]),
                .sample_ch(ch_w[gi]), .sample_data(data_w[gi]), .alarm(alarm_w[gi]),
                .thr_hi(thr_hi), .thr_lo(thr_lo)
            );

            always @(negedge cs_w[gi]) begin
                rise_cnt = 0;
                cmd_cap  = '0;
                cur_val  = conv_tab[gi][fidx % 32];
                fidx++;
            end
            always @(posedge cs_w[gi]) begin
                last_rises = rise_cnt;
                last_cmd   = cmd_cap;
            end
            always @(posedge sclk_w[gi]) begin
                rise_cnt++;
                sedges++;
                if (rise_cnt <= 5) cmd_cap = {cmd_cap[3:0], din_w[gi]};
            end
            always @(negedge sclk_w[gi]) begin
                if (rise_cnt >= 6 && rise_cnt <= 15) dout_m = cur_val[15 - rise_cnt];
                else dout_m = 1'b0;
            end
            always @(posedge clk) begin
                if (valid_w[gi] === 1'b1) begin
                    vlog[vn % 128] = {ch_w[gi], data_w[gi]};
                    vn++;
                end
                if (busy_w[gi] === 1'b1 && cs_w[gi] === 1'b1) begin
                    cs_hi_cnt++;
                end else if (cs_w[gi] === 1'b0) begin
                    if (cs_hi_cnt > 0 && cs_hi_cnt < min_gap) min_gap = cs_hi_cnt;
                    cs_hi_cnt = 0;
                end
            end
        end
    endgenerate

    task automatic pulse_start(input int inst);
        @(negedge clk);
        start_r[inst] = 1'b1;
        @(negedge clk);
        start_r[inst] = 1'b0;
    endtask

    task automatic wait_idle(input int inst, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (busy_w[inst] === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++; if (cs_w[i] !== 1'b1) begin failures++; $display("FAIL reset_cs[%0d] got=%b exp=1", i, cs_w[i]); end
            checks++; if (sclk_w[i] !== 1'b0) begin failures++; $display("FAIL reset_sclk[%0d] got=%b exp=0", i, sclk_w[i]); end
            checks++; if (din_w[i] !== 1'b0) begin failures++; $display("FAIL reset_din[%0d] got=%b exp=0", i, din_w[i]); end
            checks++; if (busy_w[i] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, busy_w[i]); end
            checks++; if (valid_w[i] !== 1'b0) begin failures++; $display("FAIL reset_valid[%0d] got=%b exp=0", i, valid_w[i]); end
            checks++; if ({ch_w[i], data_w[i]} !== 13'd0) begin failures++; $display("FAIL reset_sample[%0d] got=%h exp=0", i, {ch_w[i], data_w[i]}); end
            checks++; if (alarm_w[i] !== 1'b0) begin failures++; $display("FAIL reset_alarm[%0d] got=%b exp=0", i, alarm_w[i]); end
        end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single_frame;
        int base;
        bit ok;
        base = g_dut[0].vn;
        conv_tab[0][g_dut[0].fidx % 32] = 10'h2A5;
        mask_r[0] = 8'h08;
        pulse_start(0);
        wait_idle(0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=busy exp=idle"); end
        checks++; if (g_dut[0].last_cmd !== 5'b11011) begin failures++; $display("FAIL single_cmd got=%b exp=11011", g_dut[0].last_cmd); end
        checks++; if (g_dut[0].last_rises != 16) begin failures++; $display("FAIL single_rises got=%0d exp=16", g_dut[0].last_rises); end
        checks++; if (g_dut[0].vn - base != 1) begin failures++; $display("FAIL single_nvalid got=%0d exp=1", g_dut[0].vn - base); end
        checks++; if (g_dut[0].vlog[base % 128] !== {3'd3, 10'h2A5}) begin failures++; $display("FAIL single_sample got=%h exp=%h", g_dut[0].vlog[base % 128], {3'd3, 10'h2A5}); end
        checks++; if (cs_w[0] !== 1'b1 || sclk_w[0] !== 1'b0) begin failures++; $display("FAIL single_idle_pins got=cs%b/sclk%b exp=cs1/sclk0", cs_w[0], sclk_w[0]); end
        repeat (5) @(negedge clk);
        checks++; if (data_w[0] !== 10'h2A5 || ch_w[0] !== 3'd3) begin failures++; $display("FAIL single_hold got=%0d/%h exp=3/2a5", ch_w[0], data_w[0]); end
        $display("test_single_frame ch=%0d data=%h", ch_w[0], data_w[0]);
    endtask

    task automatic test_average;
        int base, f0;
        bit ok;
        base = g_dut[1].vn;
        f0 = g_dut[1].fidx;
        conv_tab[1][(f0 + 0) % 32] = 10'd100;
        conv_tab[1][(f0 + 1) % 32] = 10'd101;
        conv_tab[1][(f0 + 2) % 32] = 10'd102;
        conv_tab[1][(f0 + 3) % 32] = 10'd104;
        mask_r[1] = 8'h01;
        pulse_start(1);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (g_dut[1].fidx == f0 + 4) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin failures++; $display("FAIL avg_frame4_timeout got=%0d exp=%0d", g_dut[1].fidx - f0, 4); end
        checks++; if (g_dut[1].vn != base) begin failures++; $display("FAIL avg_early_valid got=%0d exp=0", g_dut[1].vn - base); end
        wait_idle(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL avg_timeout got=busy exp=idle"); end
        checks++; if (g_dut[1].vn - base != 1) begin failures++; $display("FAIL avg_nvalid got=%0d exp=1", g_dut[1].vn - base); end
        checks++; if (g_dut[1].vlog[base % 128] !== {3'd0, 10'd101}) begin failures++; $display("FAIL avg_sample got=%h exp=%h", g_dut[1].vlog[base % 128], {3'd0, 10'd101}); end
        $display("test_average data=%0d", data_w[1]);
    endtask

    task automatic test_continuous;
        int base, f0;
        bit ok;
        logic [2:0] exp_ch [6];
        logic [AB-1:0] val;
        exp_ch = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2, 3'd7};
        base = g_dut[0].vn;
        f0 = g_dut[0].fidx;
        for (int k = 0; k < 6; k++) conv_tab[0][(f0 + k) % 32] = 10'h100 + 10'(k * 16);
        mask_r[0] = 8'h85;
        cont_r[0] = 1'b1;
        pulse_start(0);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (g_dut[0].vn >= base + 5) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin failures++; $display("FAIL cont_five_timeout got=%0d exp=5", g_dut[0].vn - base); end
        cont_r[0] = 1'b0;
        wait_idle(0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL cont_stop_timeout got=busy exp=idle"); end
        repeat (20) @(negedge clk);
        checks++; if (g_dut[0].vn - base != 6) begin failures++; $display("FAIL cont_nvalid got=%0d exp=6", g_dut[0].vn - base); end
        for (int k = 0; k < 6; k++) begin
            val = 10'h100 + 10'(k * 16);
            checks++;
            if (g_dut[0].vlog[(base + k) % 128] !== {exp_ch[k], val}) begin
                failures++;
                $display("FAIL cont_sample%0d got=%h exp=%h", k, g_dut[0].vlog[(base + k) % 128], {exp_ch[k], val});
            end
        end
        checks++; if (g_dut[0].min_gap < 8) begin failures++; $display("FAIL cont_cs_gap got=%0d exp>=8", g_dut[0].min_gap); end
        $display("test_continuous valids=%0d min_gap=%0d", g_dut[0].vn - base, g_dut[0].min_gap);
    endtask

    task automatic test_reset_mid_frame;
        int base;
        bit ok;
        base = g_dut[0].vn;
        conv_tab[0][g_dut[0].fidx % 32] = 10'h3FF;
        mask_r[0] = 8'h02;
        pulse_start(0);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (g_dut[0].rise_cnt == 9 && cs_w[0] === 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_edge9_timeout got=%0d exp=9", g_dut[0].rise_cnt); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (cs_w[0] !== 1'b1 || sclk_w[0] !== 1'b0) begin failures++; $display("FAIL rstmid_pins got=cs%b/sclk%b exp=cs1/sclk0", cs_w[0], sclk_w[0]); end
        checks++; if (busy_w[0] !== 1'b0 || data_w[0] !== 10'd0) begin failures++; $display("FAIL rstmid_state got=busy%b/data%h exp=busy0/data0", busy_w[0], data_w[0]); end
        rst = 1'b0;
        repeat (100) @(negedge clk);
        checks++; if (g_dut[0].vn != base) begin failures++; $display("FAIL rstmid_no_valid got=%0d exp=0", g_dut[0].vn - base); end
        conv_tab[0][g_dut[0].fidx % 32] = 10'h155;
        pulse_start(0);
        wait_idle(0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_restart_timeout got=busy exp=idle"); end
        checks++; if (g_dut[0].last_cmd !== 5'b11001 || g_dut[0].last_rises != 16) begin failures++; $display("FAIL rstmid_frame got=cmd%b/rises%0d exp=cmd11001/rises16", g_dut[0].last_cmd, g_dut[0].last_rises); end
        checks++; if (g_dut[0].vn - base != 1 || g_dut[0].vlog[base % 128] !== {3'd1, 10'h155}) begin failures++; $display("FAIL rstmid_sample got=n%0d/%h exp=n1/%h", g_dut[0].vn - base, g_dut[0].vlog[base % 128], {3'd1, 10'h155}); end
        $display("test_reset_mid_frame data=%h", data_w[0]);
    endtask

    task automatic test_empty_and_busy_start;
        int base, f0, e0;
        bit ok, saw_busy, saw_cs_low;
        base = g_dut[0].vn;
        f0 = g_dut[0].fidx;
        e0 = g_dut[0].sedges;
        mask_r[0] = 8'h00;
        pulse_start(0);
        saw_busy = 1'b0;
        saw_cs_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy_w[0] !== 1'b0) saw_busy = 1'b1;
            if (cs_w[0] !== 1'b1) saw_cs_low = 1'b1;
        end
        checks++; if (saw_busy) begin failures++; $display("FAIL empty_busy got=1 exp=0"); end
        checks++; if (saw_cs_low || g_dut[0].sedges != e0) begin failures++; $display("FAIL empty_bus got=cs_low%b/sclk_edges%0d exp=0/0", saw_cs_low, g_dut[0].sedges - e0); end
        conv_tab[0][f0 % 32] = 10'd100;
        conv_tab[0][(f0 + 1) % 32] = 10'd900;
        mask_r[0] = 8'h01;
        pulse_start(0);
        repeat (30) @(negedge clk);
        mask_r[0] = 8'h80;
        pulse_start(0);
        wait_idle(0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL busystart_timeout got=busy exp=idle"); end
        repeat (20) @(negedge clk);
        checks++; if (g_dut[0].fidx - f0 != 1) begin failures++; $display("FAIL busystart_frames got=%0d exp=1", g_dut[0].fidx - f0); end
        checks++; if (g_dut[0].vn - base != 1 || g_dut[0].vlog[base % 128] !== {3'd0, 10'd100}) begin failures++; $display("FAIL busystart_sample got=n%0d/%h exp=n1/%h", g_dut[0].vn - base, g_dut[0].vlog[base % 128], {3'd0, 10'd100}); end
        $display("test_empty_and_busy_start frames=%0d", g_dut[0].fidx - f0);
    endtask

    task automatic test_alarm;
        bit ok;
        logic [AB-1:0] vals [4];
        logic exp_al [4];
        vals = '{10'd550, 10'd610, 10'd550, 10'd490};
`ifdef ADC_ALARM_EN
        exp_al = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
        exp_al = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int k = 0; k < 4; k++) begin
            conv_tab[0][g_dut[0].fidx % 32] = vals[k];
            mask_r[0] = 8'h01;
            pulse_start(0);
            wait_idle(0, ok);
            checks++; if (!ok) begin failures++; $display("FAIL alarm%0d_timeout got=busy exp=idle", k); end
            checks++; if (data_w[0] !== vals[k]) begin failures++; $display("FAIL alarm%0d_data got=%0d exp=%0d", k, data_w[0], vals[k]); end
            checks++; if (alarm_w[0] !== exp_al[k]) begin failures++; $display("FAIL alarm%0d_flag got=%b exp=%b", k, alarm_w[0], exp_al[k]); end
            $display("test_alarm sample=%0d alarm=%b", data_w[0], alarm_w[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_r[i] = 1'b0;
            cont_r[i]  = 1'b0;
            mask_r[i]  = 8'h00;
            for (int k = 0; k < 32; k++) conv_tab[i][k] = '0;
        end
        thr_hi = 10'd600;
        thr_lo = 10'd500;
        test_reset;
        test_single_frame;
        test_average;
        test_continuous;
        test_reset_mid_frame;
        test_empty_and_busy_start;
        test_alarm;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
